// File: rtl/field_line_clear_if.sv
// Handshake and data bundle between the lock/merge stage and the line-clear block.
interface field_line_clear_if #(
  parameter int WIDTH   = 20,
  parameter int HEIGHT  = 20,
  parameter int CNT_W   = 5,
  parameter int TOTAL_W = 16
);
  logic                      start;
  logic [WIDTH*HEIGHT-1:0]   field_in;
  logic                      busy;
  logic                      done;
  logic [WIDTH*HEIGHT-1:0]   field_out;
  logic [CNT_W-1:0]          lines_cleared;
  logic [TOTAL_W-1:0]        total_lines;

  modport master (
    output start, field_in,
    input  busy, done, field_out, lines_cleared, total_lines
  );

  modport slave (
    input  start, field_in,
    output busy, done, field_out, lines_cleared, total_lines
  );
endinterface

// File: rtl/field_line_clear.sv
// Removes full rows from a locked playfield, compacting survivors downward
// one row per cycle, then zero-fills the vacated top rows.
module field_line_clear #(
  parameter int WIDTH   = 20,
  parameter int HEIGHT  = 20,
  parameter int CNT_W   = 5,
  parameter int TOTAL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  field_line_clear_if.slave bus
);
  localparam int PTR_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int FW    = WIDTH * HEIGHT;

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      buf_q, buf_d;
  logic [FW-1:0]      field_out_q, field_out_d;
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, lines_q, lines_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   row_rd;
  logic [TOTAL_W:0]   total_sum;

  assign row_rd    = buf_q[int'(rd_q)*WIDTH +: WIDTH];
  assign total_sum = {1'b0, total_q} + (TOTAL_W+1)'(cnt_q);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    field_out_d = field_out_q;
    lines_d     = lines_q;
    total_d     = total_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          buf_d   = bus.field_in;
          rd_d    = PTR_W'(HEIGHT - 1);
          wr_d    = PTR_W'(HEIGHT - 1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (&row_rd) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          buf_d[int'(wr_q)*WIDTH +: WIDTH] = row_rd;
          // wr only reaches 0 on the last scan row when nothing was cleared
          if (wr_q != '0) wr_d = wr_q - PTR_W'(1);
        end
        if (rd_q != '0) begin
          rd_d = rd_q - PTR_W'(1);
        end else if (cnt_d == '0) begin
          state_d     = DONE;
          done_d      = 1'b1;
          field_out_d = buf_d;
          lines_d     = cnt_d;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        buf_d[int'(wr_q)*WIDTH +: WIDTH] = '0;
        if (wr_q != '0) begin
          wr_d = wr_q - PTR_W'(1);
        end else begin
          state_d     = DONE;
          done_d      = 1'b1;
          field_out_d = buf_d;
          lines_d     = cnt_q;
        end
      end
      DONE: begin
        total_d = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      field_out_q <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      lines_q     <= '0;
      total_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      field_out_q <= field_out_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      lines_q     <= lines_d;
      total_q     <= total_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.field_out     = field_out_q;
  assign bus.lines_cleared = lines_q;
  assign bus.total_lines   = total_q;
endmodule
